// File: rtl/data_ram.sv
// data_ram: byte-lane data memory for the pipelined RV32I core with one-cycle sized loads.
// Define DRAM_ERR_EN to add access legality checking and sticky error capture.
module data_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [2:0]  size_i,
  output logic [31:0] rdata_o,
  input  logic        err_clr_i,
  output logic        err_o,
  output logic [31:0] err_addr_o
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rel_addr;
  logic [AW-1:0] word_idx;
  logic [1:0]    offset;
  logic          size_load_ok;
  logic          size_store_ok;
  logic          store_ok;
  logic          load_ok;
  logic          do_write;
  logic          do_read;
  logic [3:0]    byte_en;
  logic [31:0]   lane_data;
  logic          rd_valid;
  logic [31:0]   rd_word;
  logic [2:0]    rd_size;
  logic [1:0]    rd_off;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic          unused_bits;

  assign rel_addr = addr_i - BASE_ADDR;
  assign word_idx = rel_addr[AW+1:2];
  assign offset   = addr_i[1:0];

  assign size_store_ok = (size_i == 3'b000) || (size_i == 3'b001) || (size_i == 3'b010);
  assign size_load_ok  = size_store_ok || (size_i == 3'b100) || (size_i == 3'b101);

`ifdef DRAM_ERR_EN
  logic align_ok;
  logic in_range;
  logic access_err;
  logic err_q;
  logic [31:0] err_addr_q;

  always_comb begin
    align_ok = 1'b1;
    if (size_i[1:0] == 2'b01)
      align_ok = ~offset[0];
    else if (size_i[1:0] == 2'b10)
      align_ok = (offset == 2'b00);
  end

  // Subtracting the base makes addresses below it wrap high, so one compare covers both ends.
  assign in_range   = (rel_addr >> (AW + 2)) == 32'd0;
  assign store_ok   = size_store_ok & align_ok & in_range;
  assign load_ok    = size_load_ok & align_ok & in_range;
  assign access_err = (we_i & re_i) | (we_i & ~store_ok) | (re_i & ~load_ok);

  // A new error in the same cycle as a clear wins and recaptures the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else if (access_err && (err_clr_i || !err_q)) begin
      err_q      <= 1'b1;
      err_addr_q <= addr_i;
    end else if (err_clr_i) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end
  end

  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign unused_bits = ^rel_addr[1:0];
`else
  assign store_ok    = size_store_ok;
  assign load_ok     = size_load_ok;
  assign err_o       = 1'b0;
  assign err_addr_o  = 32'd0;
  assign unused_bits = ^{err_clr_i, rel_addr[31:AW+2], rel_addr[1:0]};
`endif

  assign do_write = we_i & store_ok;
  assign do_read  = re_i & ~we_i & load_ok;

  always_comb begin
    byte_en   = 4'b0000;
    lane_data = wdata_i;
    case (size_i)
      3'b000: begin
        byte_en   = 4'b0001 << offset;
        lane_data = {4{wdata_i[7:0]}};
      end
      3'b001: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_i[15:0]}};
      end
      3'b010:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Qualifying with rst drops a store whose edge lands while reset is held.
  always_ff @(posedge clk) begin
    if (do_write && rst) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_word  <= 32'd0;
      rd_size  <= 3'd0;
      rd_off   <= 2'd0;
    end else begin
      rd_valid <= do_read;
      if (do_read) begin
        rd_word <= mem[word_idx];
        rd_size <= size_i;
        rd_off  <= offset;
      end
    end
  end

  always_comb begin
    rd_byte = rd_word[8*rd_off +: 8];
    rd_half = rd_off[1] ? rd_word[31:16] : rd_word[15:0];
    rdata_o = 32'd0;
    if (rd_valid) begin
      case (rd_size)
        3'b000:  rdata_o = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  rdata_o = {24'd0, rd_byte};
        3'b001:  rdata_o = {{16{rd_half[15]}}, rd_half};
        3'b101:  rdata_o = {16'd0, rd_half};
        3'b010:  rdata_o = rd_word;
        default: rdata_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed and random load/store sequence for data_ram checked against a byte-array model.
// Works with or without DRAM_ERR_EN defined; expectations follow the same macro.
module tb_data_ram;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam longint      SPAN  = longint'(DEPTH) * 4;

  logic        clk;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        we_i;
  logic        re_i;
  logic [2:0]  size_i;
  logic [31:0] rdata_o;
  logic        err_clr_i;
  logic        err_o;
  logic [31:0] err_addr_o;

  int          checks;
  int          errors;
  logic [7:0]  mem_model [0:DEPTH*4-1];
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] exp_err_addr;

  data_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i), .re_i(re_i),
    .size_i(size_i), .rdata_o(rdata_o), .err_clr_i(err_clr_i), .err_o(err_o),
    .err_addr_o(err_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int numBytes(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Reference behaviour: compute what one request cycle does to the byte array and outputs.
  task automatic modelStep(input logic we, input logic re, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input logic clr);
    longint rel;
    longint ba;
    longint v;
    int     n;
    bit     st_ok;
    bit     ld_ok;
    bit     ev;
    bit     sz_st;
    bit     sz_ld;
    bit     aligned;
    bit     in_range;
    n        = numBytes(sz);
    sz_ld    = (n != 0);
    sz_st    = (n != 0) && (sz[2] == 1'b0);
    if (n == 0) n = 1;
    rel      = longint'(a) - longint'(BASE);
    in_range = (rel >= 0) && (rel < SPAN);
    aligned  = (longint'(a) % n) == 0;
`ifdef DRAM_ERR_EN
    st_ok = we && sz_st && aligned && in_range;
    ld_ok = re && !we && sz_ld && aligned && in_range;
    ev    = (we && re) || (we && !st_ok) || (re && !we && !ld_ok);
`else
    st_ok = we && sz_st;
    ld_ok = re && !we && sz_ld;
    ev    = 1'b0;
`endif
    ba = ((rel % SPAN) + SPAN) % SPAN;
    ba = ba - (ba % n);
    v  = 0;
    for (int k = 0; k < n; k++) v += longint'(mem_model[ba + k]) << (8 * k);
    if (sz[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    exp_rdata = ld_ok ? v[31:0] : 32'd0;
    if (st_ok)
      for (int k = 0; k < n; k++) mem_model[ba + k] = 8'((wd >> (8 * k)) & 32'hFF);
`ifdef DRAM_ERR_EN
    if (ev && (clr || !exp_err)) begin
      exp_err      = 1'b1;
      exp_err_addr = a;
    end else if (clr) begin
      exp_err      = 1'b0;
      exp_err_addr = 32'd0;
    end
`else
    if (ev || clr) exp_err = 1'b0;
`endif
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".rdata"}, rdata_o, exp_rdata);
    checkValue({tag, ".err"}, {31'd0, err_o}, {31'd0, exp_err});
    checkValue({tag, ".err_addr"}, err_addr_o, exp_err_addr);
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd, input logic clr);
    we_i      = we;
    re_i      = re;
    size_i    = sz;
    addr_i    = a;
    wdata_i   = wd;
    err_clr_i = clr;
    @(posedge clk);
    #1;
    modelStep(we, re, sz, a, wd, clr);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] a;
    logic        we;
    logic        re;
    int          r;
    int          n;
    checks       = 0;
    errors       = 0;
    exp_rdata    = 32'd0;
    exp_err      = 1'b0;
    exp_err_addr = 32'd0;
    rst = 1'b0; we_i = 1'b0; re_i = 1'b0; size_i = 3'd0; addr_i = 32'd0;
    wdata_i = 32'd0; err_clr_i = 1'b0;
    #3;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] filling memory");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 3'b010, BASE + 32'(i * 4), $urandom, 1'b0);
      if (i % 16 == 0) checkOutput("fill");
    end

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h8000_00FF, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h10, 32'd0, 1'b0);
    checkOutput("lb");
    checkValue("lb_const", rdata_o, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h10, 32'd0, 1'b0);
    checkValue("lbu_const", rdata_o, 32'h0000_00FF);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h12, 32'd0, 1'b0);
    checkValue("lh_const", rdata_o, 32'hFFFF_8000);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'd0, 1'b0);
    checkValue("lw_const", rdata_o, 32'h8000_00FF);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 1'b0);
    checkOutput("idle");

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h1122_3344, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h22, 32'h0000_00AA, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h20, 32'd0, 1'b0);
    checkValue("sb_lanes", rdata_o, 32'h11AA_3344);

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h6, 32'd0, 1'b0);
    checkOutput("lw_misaligned");
`ifdef DRAM_ERR_EN
    checkValue("err_first_addr", err_addr_o, 32'h6);
`endif
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h9, 32'd0, 1'b0);
    checkOutput("second_err");
    applyStimulus(1'b0, 1'b1, 3'b011, 32'h20, 32'd0, 1'b1);
    checkOutput("clr_and_err");
`ifdef DRAM_ERR_EN
    checkValue("clr_new_addr", err_addr_o, 32'h20);
`endif

    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0123_4567, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, BASE + 32'(SPAN), 32'hDEAD_BEEF, 1'b0);
    checkOutput("boundary_store");
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0, 32'd0, 1'b0);
    checkOutput("boundary_load");
`ifdef DRAM_ERR_EN
    checkValue("boundary_nowrite", rdata_o, 32'h0123_4567);
    checkValue("boundary_err_addr", err_addr_o, BASE + 32'(SPAN));
`else
    checkValue("boundary_wrap", rdata_o, 32'hDEAD_BEEF);
`endif
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h30, 32'h5555_AAAA, 1'b1);
    checkOutput("we_and_re");

    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 99);
      we = (r < 40) || (r >= 95);
      re = (r >= 40 && r < 85) || (r >= 95);
      r  = $urandom_range(0, 19);
      case (r)
        0:       sz = 3'b011;
        1:       sz = 3'b110;
        2:       sz = 3'b111;
        default: sz = 3'(($urandom_range(0, 4) == 4) ? 3'b101 : $urandom_range(0, 2) + (($urandom_range(0, 3) == 0) ? 4 : 0));
      endcase
      n = numBytes(sz);
      a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      if ($urandom_range(0, 9) < 8 && n != 0) a = a + 32'($urandom_range(0, 3) & ~(n - 1) & 3);
      else a = a + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = BASE + 32'(SPAN) + 32'($urandom_range(0, 255));
      applyStimulus(we, re, sz, a, $urandom, ($urandom_range(0, 19) == 0));
      checkOutput("random");
    end

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h6, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h40, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h40, 32'd0, 1'b0);
    checkValue("pre_reset_rdata", rdata_o, 32'hCAFE_F00D);
    we_i = 1'b0;
    re_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkValue("async_rst_rdata", rdata_o, 32'd0);
    checkValue("async_rst_err", {31'd0, err_o}, 32'd0);
    checkValue("async_rst_err_addr", err_addr_o, 32'd0);
    exp_rdata    = 32'd0;
    exp_err      = 1'b0;
    exp_err_addr = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h40, 32'd0, 1'b0);
    checkOutput("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
